// File: rtl/spi_reg_master_if.sv
// Host-side request/response bundle of the SPI register-read master.
// The local controller uses the master modport; the SPI engine uses the slave modport.
interface spi_reg_master_if;
  logic       start;
  logic [7:0] start_addr;
  logic [3:0] count;
  logic       busy;
  logic [7:0] rd_data;
  logic [7:0] rd_addr;
  logic       rd_valid;
  logic       done;

  modport master (
    output start, start_addr, count,
    input  busy, rd_data, rd_addr, rd_valid, done
  );

  modport slave (
    input  start, start_addr, count,
    output busy, rd_data, rd_addr, rd_valid, done
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI register-read master (Mode 0, MSB first). Each pair sends an address
// byte and receives a data byte under one continuous chip select; a burst
// walks consecutive addresses with 8-bit wraparound.
module spi_reg_master #(
  parameter int CLK_DIV = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_reg_master_if.slave   host,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          phase, phase_nx;       // 0 = SCK low half, 1 = SCK high half
  logic [3:0]    bit_idx, bit_idx_nx;   // 0..15 within one address/data pair
  logic [7:0]    addr, addr_nx;
  logic [3:0]    remain, remain_nx;     // pairs left including the current one
  logic [7:0]    tx_sh, tx_sh_nx;       // address shifter; empties to zero after 8 bits
  logic [7:0]    rx_sh, rx_sh_nx;
  logic          sck_nx, mosi_nx, cs_n_nx;
  logic          busy, busy_nx;
  logic          rd_valid, rd_valid_nx;
  logic          done, done_nx;
  logic [7:0]    rd_data, rd_data_nx;
  logic [7:0]    rd_addr, rd_addr_nx;
  logic [7:0]    addr_inc;

  assign addr_inc = addr + 8'd1;

  assign host.busy     = busy;
  assign host.rd_valid = rd_valid;
  assign host.done     = done;
  assign host.rd_data  = rd_data;
  assign host.rd_addr  = rd_addr;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= 1'b0;
      bit_idx  <= 4'd0;
      addr     <= 8'h00;
      remain   <= 4'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      rd_data  <= 8'h00;
      rd_addr  <= 8'h00;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      phase    <= phase_nx;
      bit_idx  <= bit_idx_nx;
      addr     <= addr_nx;
      remain   <= remain_nx;
      tx_sh    <= tx_sh_nx;
      rx_sh    <= rx_sh_nx;
      spi_sck  <= sck_nx;
      spi_mosi <= mosi_nx;
      spi_cs_n <= cs_n_nx;
      busy     <= busy_nx;
      rd_valid <= rd_valid_nx;
      done     <= done_nx;
      rd_data  <= rd_data_nx;
      rd_addr  <= rd_addr_nx;
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    phase_nx    = phase;
    bit_idx_nx  = bit_idx;
    addr_nx     = addr;
    remain_nx   = remain;
    tx_sh_nx    = tx_sh;
    rx_sh_nx    = rx_sh;
    sck_nx      = spi_sck;
    mosi_nx     = spi_mosi;
    cs_n_nx     = spi_cs_n;
    busy_nx     = busy;
    rd_valid_nx = 1'b0;
    done_nx     = 1'b0;
    rd_data_nx  = rd_data;
    rd_addr_nx  = rd_addr;

    unique case (state)
      IDLE: begin
        if (host.start) begin
          if (host.count != 4'd0) begin
            state_nx  = SETUP;
            cnt_nx    = '0;
            addr_nx   = host.start_addr;
            remain_nx = host.count;
            tx_sh_nx  = host.start_addr;
            mosi_nx   = host.start_addr[7];
            sck_nx    = 1'b0;
            cs_n_nx   = 1'b0;
            busy_nx   = 1'b1;
          end else begin
            // Empty burst: acknowledge without touching the bus.
            done_nx = 1'b1;
          end
        end
      end

      SETUP: begin
        if (cnt == CNT_LAST) begin
          state_nx   = XFER;
          cnt_nx     = '0;
          phase_nx   = 1'b0;
          bit_idx_nx = 4'd0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      XFER: begin
        if (cnt != CNT_LAST) begin
          cnt_nx = cnt + 1'b1;
        end else if (!phase) begin
          // Rising edge: the data half of the pair samples MISO here.
          cnt_nx   = '0;
          phase_nx = 1'b1;
          sck_nx   = 1'b1;
          if (bit_idx[3]) begin
            rx_sh_nx = {rx_sh[6:0], spi_miso};
          end
        end else begin
          // Falling edge: start of the next bit's low half, MOSI changes here.
          cnt_nx   = '0;
          phase_nx = 1'b0;
          sck_nx   = 1'b0;
          if (bit_idx == 4'd15) begin
            rd_valid_nx = 1'b1;
            rd_data_nx  = rx_sh;
            rd_addr_nx  = addr;
            if (remain > 4'd1) begin
              addr_nx    = addr_inc;
              remain_nx  = remain - 4'd1;
              bit_idx_nx = 4'd0;
              tx_sh_nx   = addr_inc;
              mosi_nx    = addr_inc[7];
            end else begin
              state_nx = HOLD;
              mosi_nx  = 1'b0;
            end
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
            tx_sh_nx   = {tx_sh[6:0], 1'b0};
            mosi_nx    = tx_sh[6];
          end
        end
      end

      HOLD: begin
        if (cnt == CNT_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
          cs_n_nx  = 1'b1;
          mosi_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      GAP: begin
        if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Testbench for spi_reg_master: two instances (CLK_DIV=5 and CLK_DIV=2)
// share one behavioural Mode-0 SPI slave through a selector.
module tb_spi_reg_master;

  localparam int CD5 = 5;
  localparam int CD2 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic       start;
  logic [7:0] start_addr;
  logic [3:0] count;
  int         sel;
  logic       miso;

  spi_reg_master_if if5 ();
  spi_reg_master_if if2 ();

  assign if5.start      = start && (sel == 0);
  assign if5.start_addr = start_addr;
  assign if5.count      = count;
  assign if2.start      = start && (sel == 1);
  assign if2.start_addr = start_addr;
  assign if2.count      = count;

  logic sck5, mosi5, cs5, sck2, mosi2, cs2;

  spi_reg_master #(.CLK_DIV(CD5)) dut5 (
    .clk(clk), .rst_n(rst_n), .host(if5.slave),
    .spi_sck(sck5), .spi_mosi(mosi5), .spi_miso(miso), .spi_cs_n(cs5)
  );

  spi_reg_master #(.CLK_DIV(CD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .host(if2.slave),
    .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso), .spi_cs_n(cs2)
  );

  logic       m_sck, m_mosi, m_cs_n, m_busy, m_rd_valid, m_done;
  logic [7:0] m_rd_data, m_rd_addr;
  assign m_sck      = (sel == 1) ? sck2         : sck5;
  assign m_mosi     = (sel == 1) ? mosi2        : mosi5;
  assign m_cs_n     = (sel == 1) ? cs2          : cs5;
  assign m_busy     = (sel == 1) ? if2.busy     : if5.busy;
  assign m_rd_valid = (sel == 1) ? if2.rd_valid : if5.rd_valid;
  assign m_done     = (sel == 1) ? if2.done     : if5.done;
  assign m_rd_data  = (sel == 1) ? if2.rd_data  : if5.rd_data;
  assign m_rd_addr  = (sel == 1) ? if2.rd_addr  : if5.rd_addr;

  // Slave model: captures the address on rising edges, returns either 0xA5
  // or the inverted address, shifting on falling edges.
  bit         slave_inv;
  int         sbit = 0;
  logic       sprev = 1'b0;
  logic [7:0] srx = 8'h00;
  logic [7:0] stx = 8'h00;
  logic [7:0] slv_q[$];
  initial miso = 1'b0;

  always @(m_sck or m_cs_n) begin
    if (m_cs_n) begin
      sbit = 0;
      miso = 1'b0;
    end else if (m_sck && !sprev) begin
      if (sbit < 8) srx = {srx[6:0], m_mosi};
      sbit = sbit + 1;
      if (sbit == 8) slv_q.push_back(srx);
    end else if (!m_sck && sprev) begin
      if (sbit == 8) begin
        stx  = slave_inv ? ~srx : 8'hA5;
        miso = stx[7];
      end else if (sbit > 8 && sbit < 16) begin
        stx  = {stx[6:0], 1'b0};
        miso = stx[7];
      end else if (sbit == 16) begin
        sbit = 0;
        miso = 1'b0;
      end
    end
    sprev = m_sck;
  end

  // Event recorder, sampled 1 time unit after each rising clock edge.
  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } rv_t;

  rv_t  rv_q[$];
  int   done_q[$];
  int   rise_q[$];
  int   hilen_q[$];
  int   csrise_q[$];
  int   csfall_q[$];
  int   cyc = 0;
  int   hicnt = 0;
  logic psck = 1'b0;
  logic pcs = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (m_rd_valid) rv_q.push_back('{cyc, m_rd_addr, m_rd_data});
    if (m_done) done_q.push_back(cyc);
    if (m_sck && !psck) begin
      rise_q.push_back(cyc);
      hicnt = 0;
    end
    if (m_sck) hicnt = hicnt + 1;
    if (!m_sck && psck) hilen_q.push_back(hicnt);
    if (m_cs_n && !pcs) csrise_q.push_back(cyc);
    if (!m_cs_n && pcs) csfall_q.push_back(cyc);
    psck = m_sck;
    pcs  = m_cs_n;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] addr;
    logic [3:0] cnt;
    bit         inv;
    int         rv0;        // offset of first rd_valid from accepted start
    int         done_off;
    int         rises;
    int         first_rise;
  } vec_t;

  vec_t vt[5];

  task automatic run_vec(input vec_t v);
    int cd, t, g, n_rv, n_done, n_rise, n_hi, n_csr, n_csf, n_slv, nb, nrv;
    logic [7:0] ea, ed;
    cd     = (v.sel == 1) ? CD2 : CD5;
    n_rv   = rv_q.size();
    n_done = done_q.size();
    n_rise = rise_q.size();
    n_hi   = hilen_q.size();
    n_csr  = csrise_q.size();
    n_csf  = csfall_q.size();
    n_slv  = slv_q.size();
    sel       = v.sel;
    slave_inv = v.inv;
    @(negedge clk);
    start      = 1'b1;
    start_addr = v.addr;
    count      = v.cnt;
    t          = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_at_T1", 32'(m_busy), 32'(v.cnt != 4'd0));
    chk("csn_at_T1", 32'(m_cs_n), 32'(v.cnt == 4'd0));
    g = 0;
    while (done_q.size() == n_done && g < 4000) begin
      @(negedge clk);
      g = g + 1;
    end
    chk("done_seen", 32'(done_q.size() - n_done), 32'd1);
    if (done_q.size() > n_done) chk("done_cycle", 32'(done_q[n_done] - t), 32'(v.done_off));
    chk("busy_at_done", 32'(m_busy), 32'd0);
    nrv = rv_q.size() - n_rv;
    chk("rd_valid_count", 32'(nrv), 32'(v.cnt));
    for (int i = 0; i < nrv && i < int'(v.cnt); i++) begin
      ea = v.addr + 8'(i);
      ed = v.inv ? ~ea : 8'hA5;
      chk("rd_valid_cycle", 32'(rv_q[n_rv + i].cyc - t), 32'(v.rv0 + i * 32 * cd));
      chk("rd_addr", 32'(rv_q[n_rv + i].a), 32'(ea));
      chk("rd_data", 32'(rv_q[n_rv + i].d), 32'(ed));
    end
    chk("sck_rises", 32'(rise_q.size() - n_rise), 32'(v.rises));
    if (v.rises > 0 && rise_q.size() > n_rise)
      chk("first_sck_rise", 32'(rise_q[n_rise] - t), 32'(v.first_rise));
    nb = 0;
    for (int i = n_hi; i < hilen_q.size(); i++)
      if (hilen_q[i] != cd) nb = nb + 1;
    chk("sck_high_len_errors", 32'(nb), 32'd0);
    for (int i = n_rise + 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != 2 * cd) nb = nb + 1;
    chk("sck_period_errors", 32'(nb), 32'd0);
    chk("cs_fall_count", 32'(csfall_q.size() - n_csf), 32'(v.cnt != 4'd0));
    chk("cs_rise_count", 32'(csrise_q.size() - n_csr), 32'(v.cnt != 4'd0));
    if (v.cnt != 4'd0 && csrise_q.size() > n_csr && nrv > 0) begin
      chk("last_rv_to_cs_high", 32'(csrise_q[n_csr] - rv_q[rv_q.size()-1].cyc), 32'(cd));
      if (done_q.size() > n_done)
        chk("last_rv_to_done", 32'(done_q[n_done] - rv_q[rv_q.size()-1].cyc), 32'(2 * cd));
    end
    chk("slave_addr_count", 32'(slv_q.size() - n_slv), 32'(v.cnt));
    if (v.cnt != 4'd0 && slv_q.size() > n_slv)
      chk("slave_saw_mosi_addr", 32'(slv_q[n_slv]), 32'(v.addr));
  endtask

  initial begin
    int t, n_rv, n_done, g, r, f;
    //         sel addr   cnt inv rv0  done rises first_rise
    vt[0] = '{0, 8'h03, 4'd1, 1'b0, 166, 176, 16, 11};
    vt[1] = '{0, 8'hFE, 4'd3, 1'b1, 166, 496, 48, 11};
    vt[2] = '{1, 8'h5A, 4'd2, 1'b1,  67, 135, 32,  5};
    vt[3] = '{0, 8'h80, 4'd0, 1'b0,   0,   1,  0,  0};
    vt[4] = '{0, 8'h21, 4'd1, 1'b1, 166, 176, 16, 11};

    rst_n = 1'b0;
    start = 1'b0;
    start_addr = 8'h00;
    count = 4'd0;
    sel = 0;
    slave_inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state_div5", 32'({sck5, cs5, mosi5, if5.busy, if5.rd_valid, if5.done, if5.rd_data, if5.rd_addr}), 32'h0010_0000);
    chk("reset_state_div2", 32'({sck2, cs2, mosi2, if2.busy, if2.rd_valid, if2.done, if2.rd_data, if2.rd_addr}), 32'h0010_0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // Start pulse while busy must not disturb the running burst.
    sel = 0;
    slave_inv = 1'b0;
    n_rv = rv_q.size();
    n_done = done_q.size();
    @(negedge clk);
    start = 1'b1; start_addr = 8'h03; count = 4'd1; t = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1; start_addr = 8'h10; count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (done_q.size() == n_done && g < 4000) begin
      @(negedge clk);
      g = g + 1;
    end
    repeat (200) @(negedge clk);
    chk("ignored_start_rv_count", 32'(rv_q.size() - n_rv), 32'd1);
    chk("ignored_start_done_count", 32'(done_q.size() - n_done), 32'd1);
    if (rv_q.size() > n_rv) chk("ignored_start_rd_addr", 32'(rv_q[n_rv].a), 32'h03);
    if (done_q.size() > n_done) chk("ignored_start_done_cycle", 32'(done_q[n_done] - t), 32'd176);

    // Asynchronous reset in the high half of bit 10 of the first pair.
    slave_inv = 1'b1;
    n_rv = rv_q.size();
    n_done = done_q.size();
    @(negedge clk);
    start = 1'b1; start_addr = 8'h33; count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (111) @(negedge clk);
    chk("sck_high_in_bit10", 32'(sck5), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({sck5, cs5, mosi5, if5.busy, if5.rd_valid, if5.done}), 32'b010000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("abort_no_rd_valid", 32'(rv_q.size() - n_rv), 32'd0);
    chk("abort_no_done", 32'(done_q.size() - n_done), 32'd0);
    run_vec(vt[0]);

    // Back-to-back bursts: second start issued the cycle after done.
    run_vec(vt[0]);
    r = (csrise_q.size() > 0) ? csrise_q[csrise_q.size()-1] : 0;
    run_vec(vt[4]);
    f = (csfall_q.size() > 0) ? csfall_q[csfall_q.size()-1] : 0;
    chk("cs_high_gap_ok", 32'((f - r) >= CD5), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

Register-read SPI master: FPGA-side initiator for the two-byte "address-out, data-in" SPI protocol our slave interfaces implement (Mode 0, MSB first, address byte followed by data byte, continuous pairs under one chip select). A local controller requests a burst of N register reads starting at an address. The block drives SCK/MOSI/CS_n, captures MISO, and streams each returned byte out with its address. It sits between on-FPGA control logic and an external or board-level SPI slave, and also serves as the bench driver for our slave blocks.

## Interface
- CLK_DIV, 5: SCK half-period in clk cycles; legal ≥2, use ≥4 against slaves with 3-flop input synchronizers (5 → 5 MHz SCK at 50 MHz clk).
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only when busy=0
- start_addr  input  8  first register address of burst
- count  input  4  number of address/data pairs (1..15; 0 = no bus activity)
- busy  output  1  high from cycle after accepted start until done
- rd_data  output  8  received data byte, valid when rd_valid=1
- rd_addr  output  8  address that produced rd_data
- rd_valid  output  1  one-cycle strobe per received byte
- done  output  1  one-cycle strobe at burst end
- spi_sck  output  1  SPI clock, idles low
- spi_mosi  output  1  master out
- spi_miso  input  1  master in
- spi_cs_n  output  1  chip select, active low

## Operation
- All outputs registered. Reset values: spi_sck=0, spi_cs_n=1, spi_mosi=0, busy=0, rd_valid=0, done=0, rd_data=0x00, rd_addr=0x00; state IDLE.
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE: on start with count≠0, latch start_addr/count, assert busy and spi_cs_n=0, go SETUP. count=0: done pulses next cycle, busy stays 0, no bus activity. start while busy ignored.
- SETUP: CLK_DIV cycles with CS low, SCK low; MOSI = addr[7]. Go XFER, bit index 0.
- XFER: 16 bits per pair. Each bit: SCK low CLK_DIV cycles, then high CLK_DIV cycles. MOSI updated at start of low phase (bit 0's value already presented in SETUP). Bits 0-7 send current address MSB first; bits 8-15 drive MOSI=0. MISO sampled into shift register in the clk cycle spi_sck goes 1 on bits 8-15 (first sample = data bit 7).
- End of bit 15 high phase: rd_data=shifted byte, rd_addr=current address, rd_valid=1 for one cycle. If pairs remain: address+1 (mod 256, 0xFF wraps to 0x00), remaining-1, next pair begins immediately (SCK low phase, CS stays low). Else go HOLD.
- HOLD: SCK low CLK_DIV cycles, CS still low; then spi_cs_n=1, MOSI=0, go GAP.
- GAP: CS high CLK_DIV cycles; then done=1 one cycle, busy=0 same cycle, IDLE. New start accepted the cycle after done.
- Async reset mid-burst: all outputs to reset values immediately; no rd_valid/done for the aborted burst.

## Timing
- Accepted start at cycle T: busy=1 and spi_cs_n=0 at T+1.
- First SCK rise: T+1+CLK_DIV+CLK_DIV.
- Per pair: 32·CLK_DIV cycles; first rd_valid at T+1+CLK_DIV+32·CLK_DIV (T+166 for CLK_DIV=5); later ones every 32·CLK_DIV.
- Last rd_valid to spi_cs_n=1: CLK_DIV cycles; to done: 2·CLK_DIV cycles.
- SCK duty exactly 50%, no gap between pairs or bits; MOSI stable ≥CLK_DIV cycles before each rising edge.

## Test plan
- Single read, CLK_DIV=5, addr 0x03, count 1, slave model returns 0xA5 -> MOSI 0x03 in bits 0-7, rd_valid once with rd_data=0xA5/rd_addr=0x03 at T+166, done at T+176, exactly 16 SCK rises.
- Burst wrap: addr 0xFE, count 3, slave returns ~addr -> rd_addr 0xFE, 0xFF, 0x00 with rd_data 0x01, 0x00, 0xFF; CS low continuously, 48 SCK rises.
- start during busy (addr 0x10) -> ignored, burst unchanged, no extra rd_valid; start with count=0 -> done next cycle, CS/SCK never toggle.
- Reset asserted mid-bit 10 -> spi_cs_n=1, spi_sck=0, busy=0 immediately; no rd_valid/done; next start runs a clean burst.
- CLK_DIV=2: SCK period 4 clk, 50% duty, first rd_valid at T+1+2+64=T+67; MISO sampled correctly.
- Back-to-back: start asserted the cycle after done -> accepted; CS high ≥CLK_DIV cycles between bursts.
